pipelined_adder: RTL and testbench

Parametrised, pipelined unsigned/two's-complement adder-subtractor with a valid/ready stream interface. The WIDTH-bit carry chain is split into STAGES equal slices, one slice per pipeline stage, with operands skewed in and results deskewed out, giving one result per clock at WIDTH/STAGES-bit carry-path depth. It sits in the datapath arithmetic library as the clocked, back-pressurable generalisation of the combinational 32-bit adder. It adds a single-bit carry-out, a signed-overflow flag and a subtract mode.

---
 rtl/pipelined_adder.sv | 137 +++++++++++++
 tb/tb_pipelined_adder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : Pipelined adder/subtractor with a valid/ready stream
//               interface. The WIDTH-bit carry chain is cut into STAGES
//               slices of WIDTH/STAGES bits, one slice per register stage.
//               Operand slices not yet summed are skewed through shrinking
//               delay registers. Finished sum slices travel with the beat, so
//               a whole result leaves the last stage in a single cycle.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_valid/in_ready   - operand handshake
//               in1, in2, cin, sub  - operands, carry-in, subtract mode
//               out_valid/out_ready - result handshake
//               sout, cout, ovf     - result, carry-out, signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 32,  // must be a multiple of STAGES
  parameter int STAGES = 4    // 1..WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic             ovf
);

  localparam int c_SLICE = WIDTH / STAGES;
  // Stage k still needs the operand bits above slice k-1, i.e.
  // WIDTH - k*c_SLICE bits. The operand chains pack those shrinking
  // slots back to back so that no register bit is ever left unread.
  localparam int c_OPW = STAGES * WIDTH - c_SLICE * ((STAGES * (STAGES - 1)) / 2);

  logic                        w_advance;
  logic [STAGES:0]             w_valid_chain;
  logic [STAGES:0]             w_carry_chain;
  logic [STAGES:0][WIDTH-1:0]  w_sum_chain;
  logic [c_OPW-1:0]            w_a_chain;
  logic [c_OPW-1:0]            w_b_chain;
  logic                        r_ovf;

  // A single global enable: the whole pipe moves or the whole pipe holds.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // Slot 0 of every chain is the raw beat presented at the input.
  assign w_valid_chain[0]       = in_valid;
  assign w_carry_chain[0]       = sub | cin;  // sub forces the +1 of A + ~B + 1
  assign w_sum_chain[0]         = '0;
  assign w_a_chain[WIDTH-1:0]   = in1;
  assign w_b_chain[WIDTH-1:0]   = sub ? ~in2 : in2;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int c_OFF = k * WIDTH - c_SLICE * ((k * (k - 1)) / 2);
    localparam int c_REM = WIDTH - k * c_SLICE;

    logic [c_REM-1:0]   w_a;
    logic [c_REM-1:0]   w_b;
    logic [c_SLICE:0]   w_slice;
    logic [WIDTH-1:0]   w_sum_next;
    logic               r_valid;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;

    // Lowest c_SLICE bits of the slot are this stage's operand slice.
    assign w_a     = w_a_chain[c_OFF +: c_REM];
    assign w_b     = w_b_chain[c_OFF +: c_REM];
    assign w_slice = {1'b0, w_a[c_SLICE-1:0]} + {1'b0, w_b[c_SLICE-1:0]}
                   + {{c_SLICE{1'b0}}, w_carry_chain[k]};

    always_comb begin
      w_sum_next = w_sum_chain[k];
      w_sum_next[k*c_SLICE +: c_SLICE] = w_slice[c_SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_advance) begin
        r_valid <= w_valid_chain[k];
        r_carry <= w_slice[c_SLICE];
        r_sum   <= w_sum_next;
      end
    end

    assign w_valid_chain[k+1] = r_valid;
    assign w_carry_chain[k+1] = r_carry;
    assign w_sum_chain[k+1]   = r_sum;

    if (k < STAGES - 1) begin : g_skew
      // Hand the not-yet-added upper operand bits on to the next stage.
      logic [c_REM-c_SLICE-1:0] r_a;
      logic [c_REM-c_SLICE-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a[c_REM-1:c_SLICE];
          r_b <= w_b[c_REM-1:c_SLICE];
        end
      end

      assign w_a_chain[c_OFF+c_REM +: c_REM-c_SLICE] = r_a;
      assign w_b_chain[c_OFF+c_REM +: c_REM-c_SLICE] = r_b;
    end else begin : g_ovf
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit; XOR with
      // the carry out gives two's-complement overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= w_a[c_REM-1] ^ w_b[c_REM-1] ^ w_slice[c_SLICE-1] ^ w_slice[c_SLICE];
        end
      end
    end
  end

  assign out_valid = w_valid_chain[STAGES];
  assign cout      = w_carry_chain[STAGES];
  assign sout      = w_sum_chain[STAGES];
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Self-checking bench for pipelined_adder. Directed vector
//               table, back-pressure and mid-flight reset sequences on a
//               32-bit/4-stage instance, then a randomized handshake sweep
//               on several WIDTH/STAGES configurations against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sout;
  logic          cout;
  logic          ovf;

  logic          sweep_go = 1'b0;
  int            sweep_done = 0;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sout      (sout),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        s;
    logic [31:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[12];

  // Present one beat on an empty pipe, then measure latency and result.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    in1 = v.a; in2 = v.b; cin = v.c; sub = v.s;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check($sformatf("%s in_ready", name), 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom(); in2 = $urandom(); sub = ~sub; cin = ~cin;
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s latency", name), 128'(lat), 128'(N - 1));
    check($sformatf("%s result", name), 128'({ovf, cout, sout}), 128'({v.ov, v.co, v.res}));
  endtask

  task automatic flush();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got, stale;
    logic [33:0] held;

    vecs[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[3]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'h00000007, 32'h00000007, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[8]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    vecs[10] = '{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0};
    vecs[11] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset sout", 128'(sout), 128'(0));
    check("reset cout", 128'(cout), 128'(0));
    check("reset ovf", 128'(ovf), 128'(0));
    check("reset in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    flush();

    // Back-pressure: 8 back-to-back beats, out_ready low in cycles 5..7.
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_valid  = (sent < 8);
      in1       = 32'(sent);
      in2       = 32'(sent) << 16;
      cin = 1'b0; sub = 1'b0;
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      check($sformatf("bp in_ready c%0d", cyc), 128'(in_ready), 128'(!(cyc >= 5 && cyc <= 7)));
      if (cyc >= 6 && cyc <= 7)
        check($sformatf("bp hold c%0d", cyc), 128'({out_valid, ovf, cout, sout}), 128'({1'b1, held}));
      held = {ovf, cout, sout};
      if (out_valid && out_ready) begin
        check($sformatf("bp beat%0d", got), 128'({ovf, cout, sout}), 128'(34'(got) * 34'd65537));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    check("bp all beats", 128'(got), 128'(8));
    flush();

    // Mid-flight reset before any result reaches the output.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in1 = 32'hA0 + 32'(i); in2 = 32'h0F00_0000; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("midrst pre out_valid", 128'(out_valid), 128'(0));
    rst_n = 1'b0;
    #1;
    check("midrst async out_valid", 128'(out_valid), 128'(0));
    check("midrst async sout", 128'({ovf, cout, sout}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("midrst stale beats", 128'(stale), 128'(0));
    run_vec(vecs[9], "post-reset");
    flush();

    // Reset while a finished result is stalled on the output.
    in_valid = 1'b1; out_ready = 1'b0;
    in1 = 32'h12345678; in2 = 32'h11111111; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("stallrst pre", 128'({out_valid, sout}), 128'({1'b1, 32'h23456789}));
    rst_n = 1'b0;
    #1;
    check("stallrst async", 128'({out_valid, ovf, cout, sout}), 128'(0));
    check("stallrst in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("stallrst stale beats", 128'(stale), 128'(0));

    sweep_go = 1'b1;
    for (int i = 0; i < 20000 && sweep_done < 4; i++) @(posedge clk);
    check("sweep completion", 128'(sweep_done), 128'(4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Randomized handshake sweep over several geometries.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 64 : 8;
    localparam int SN = (g == 0) ? 1 : (g == 1) ? 2  : (g == 2) ? 8  : 8;
    localparam int BEATS = 150;

    logic          s_iv, s_ir, s_ov, s_or, s_ci, s_sb, s_co, s_of;
    logic [SW-1:0] s_a, s_b, s_s;

    pipelined_adder #(.WIDTH(SW), .STAGES(SN)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .in1       (s_a),
      .in2       (s_b),
      .cin       (s_ci),
      .sub       (s_sb),
      .out_valid (s_ov),
      .out_ready (s_or),
      .sout      (s_s),
      .cout      (s_co),
      .ovf       (s_of)
    );

    // Reference: plain arithmetic on the operands, returned as {ovf, cout, sum}.
    function automatic logic [SW+1:0] model(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                            input logic c, input logic s);
      logic [SW:0]   t;
      logic [SW-1:0] r;
      logic          co, ov;
      if (s) begin
        r  = a - b;
        co = (a >= b);
        ov = (a[SW-1] != b[SW-1]) && (r[SW-1] != a[SW-1]);
      end else begin
        t  = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c};
        r  = t[SW-1:0];
        co = t[SW];
        ov = (a[SW-1] == b[SW-1]) && (r[SW-1] != a[SW-1]);
      end
      return {ov, co, r};
    endfunction

    function automatic logic [SW-1:0] rand_op();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0:       return '1;
        1:       return '0;
        2:       return {1'b1, {(SW-1){1'b0}}};
        3:       return {1'b0, {(SW-1){1'b1}}};
        default: return r[SW-1:0];
      endcase
    endfunction

    initial begin
      int            n_sent, n_got;
      logic [SW+1:0] q[$];
      logic [SW+1:0] held, exp;
      logic          was_stall;

      s_iv = 1'b0; s_or = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0; s_sb = 1'b0;
      n_sent = 0; n_got = 0; was_stall = 1'b0; held = '0;
      wait (sweep_go);
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 3000 && !(n_sent == BEATS && q.size() == 0); cyc++) begin
        s_iv = (n_sent < BEATS) && ($urandom_range(0, 9) < 7);
        s_a  = rand_op();
        s_b  = rand_op();
        s_ci = 1'($urandom_range(0, 1));
        s_sb = 1'($urandom_range(0, 1));
        s_or = ($urandom_range(0, 9) < 7);
        #1;
        check($sformatf("sweep%0d in_ready", g), 128'(s_ir), 128'(!s_ov || s_or));
        if (was_stall)
          check($sformatf("sweep%0d stall hold", g), 128'({s_ov, s_of, s_co, s_s}), 128'({1'b1, held}));
        was_stall = s_ov && !s_or;
        held = {s_of, s_co, s_s};
        if (s_iv && s_ir) begin
          q.push_back(model(s_a, s_b, s_ci, s_sb));
          n_sent++;
        end
        if (s_ov && s_or) begin
          if (q.size() == 0) begin
            check($sformatf("sweep%0d spurious output", g), 128'(s_ov), 128'(0));
          end else begin
            exp = q.pop_front();
            check($sformatf("sweep%0d beat%0d", g, n_got), 128'({s_of, s_co, s_s}), 128'(exp));
            n_got++;
          end
        end
        @(posedge clk); #1;
      end
      s_iv = 1'b0;
      check($sformatf("sweep%0d beats sent", g), 128'(n_sent), 128'(BEATS));
      check($sformatf("sweep%0d beats outstanding", g), 128'(q.size()), 128'(0));
      sweep_done++;
    end
  end

endmodule
`default_nettype wire
